// File: rtl/uart_pkg.sv
// Shared definitions for the Hamming(7,4) UART receive controller.
//   rx_fsm_e         : pairing FSM encoding (low nibble expected / high nibble expected)
//   RX_IDLE          : receiver state value meaning "no frame in flight"
//   hamming74_decode : single-error-correcting decode, returns {corrected, nibble}
package uart_pkg;

   typedef enum logic {
      IDLE_LO = 1'b0,
      WAIT_HI = 1'b1
   } rx_fsm_e;

   localparam logic [1:0] RX_IDLE = 2'b00;

   // Bit map: c[0]=p1 c[1]=p2 c[2]=d1 c[3]=p4 c[4]=d2 c[5]=d3 c[6]=d4.
   // A non-zero syndrome is the 1-based position of the flipped bit.
   function automatic logic [4:0] hamming74_decode(input logic [6:0] cw);
      logic [2:0] syn;
      logic [6:0] fixed;
      syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
      syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
      syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
      fixed  = cw;
      if (syn != 3'd0) begin
         fixed = cw ^ (7'd1 << (syn - 3'd1));
      end
      return {(syn != 3'd0), fixed[6], fixed[5], fixed[4], fixed[2]};
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and byte-sink-side signals of the UART receive controller.
//   rx_ena/rx_data/rx_valid/rx_state : link to the Hamming(7,4) receiver
//   out_data/out_valid/out_ready     : valid/ready byte stream to the host
// master = controller view, slave = receiver/consumer view.
interface uart_rx_ctrl_if;
   logic       rx_ena;
   logic [6:0] rx_data;
   logic       rx_valid;
   logic [1:0] rx_state;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output rx_ena, out_data, out_valid,
      input  rx_data, rx_valid, rx_state, out_ready
   );

   modport slave (
      input  rx_ena, out_data, out_valid,
      output rx_data, rx_valid, rx_state, out_ready
   );
endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO with registered storage and head.
//   push_i/data_i : write request (accepted when not full, or when full and popping)
//   pop_i         : remove head (ignored when empty)
//   data_o        : current head, valid while empty_o=0
//   full_o/empty_o: occupancy status
module uart_byte_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_en, rd_en;

   assign full_o  = (count_q == DepthCnt);
   assign empty_o = (count_q == '0);
   assign data_o  = mem_q[rd_ptr_q];

   // When full, a simultaneous pop frees the slot the push lands in.
   assign rd_en = pop_i & ~empty_o;
   assign wr_en = push_i & (~full_o | rd_en);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) mem_q[wr_ptr_q] <= data_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencing/framing controller for the Hamming(7,4) UART receiver.
// Generates the oversample tick, corrects incoming codewords, pairs nibbles
// (low first) into bytes and queues them for a valid/ready consumer.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : controller enable
//   bus          : receiver link and output byte stream (uart_rx_ctrl_if.master)
//   clr_err      : clear sticky flags and correction counter
//   err_overflow : sticky, byte dropped on full FIFO
//   err_timeout  : sticky, low nibble discarded after timeout
//   corr_cnt     : saturating count of corrected codewords
//   busy         : pairing in progress or receiver not idle
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_SAMPLE = 16,
   parameter int unsigned TIMEOUT_TICKS   = 256,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   uart_rx_ctrl_if.master        bus,
   input  logic                  clr_err,
   output logic                  err_overflow,
   output logic                  err_timeout,
   output logic [7:0]            corr_cnt,
   output logic                  busy
);
   localparam int unsigned      TickW    = $clog2(CLKS_PER_SAMPLE);
   localparam int unsigned      ToW      = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [TickW-1:0] TickLast = TickW'(CLKS_PER_SAMPLE - 1);
   localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_TICKS - 1);

   rx_fsm_e          state_q, state_d;
   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic             rx_ena_q, rx_ena_d;
   logic [ToW-1:0]   to_cnt_q, to_cnt_d;
   logic [3:0]       low_q, low_d;
   logic             rx_valid_q;
   logic             err_ovf_q, err_ovf_d, err_to_q, err_to_d;
   logic [7:0]       corr_q, corr_d;

   logic       cw_evt, dec_corr, push, to_evt, ovf_evt;
   logic [3:0] dec_nib;
   logic       fifo_full, fifo_empty, pop;

   // Tick generator; the registered tick is gated so en=0 silences it at once.
   always_comb begin
      tick_cnt_d = '0;
      rx_ena_d   = 1'b0;
      if (en) begin
         if (tick_cnt_q == TickLast) begin
            rx_ena_d = 1'b1;
         end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
         end
      end
   end
   assign bus.rx_ena = rx_ena_q & en;

   assign cw_evt              = en & bus.rx_valid & ~rx_valid_q;
   assign {dec_corr, dec_nib} = hamming74_decode(bus.rx_data);

   always_comb begin
      state_d  = state_q;
      low_d    = low_q;
      to_cnt_d = to_cnt_q;
      push     = 1'b0;
      to_evt   = 1'b0;
      unique case (state_q)
         IDLE_LO: begin
            if (cw_evt) begin
               low_d    = dec_nib;
               to_cnt_d = '0;
               state_d  = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (!en) begin
               low_d   = '0;
               state_d = IDLE_LO;
            end else if (cw_evt) begin
               push    = 1'b1;
               state_d = IDLE_LO;
            end else if (bus.rx_ena && (bus.rx_state == RX_IDLE)) begin
               // Counter is frozen while a frame is in flight.
               if (to_cnt_q == ToLast) begin
                  to_evt  = 1'b1;
                  low_d   = '0;
                  state_d = IDLE_LO;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   assign pop     = bus.out_valid & bus.out_ready;
   assign ovf_evt = push & fifo_full & ~bus.out_ready;

   // Error events take precedence over a same-cycle clear.
   always_comb begin
      err_ovf_d = ovf_evt | (err_ovf_q & ~clr_err);
      err_to_d  = to_evt | (err_to_q & ~clr_err);
      corr_d    = corr_q;
      if (cw_evt && dec_corr) begin
         if (clr_err)              corr_d = 8'd1;
         else if (corr_q != 8'hFF) corr_d = corr_q + 8'd1;
      end else if (clr_err) begin
         corr_d = 8'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE_LO;
         tick_cnt_q <= '0;
         rx_ena_q   <= 1'b0;
         to_cnt_q   <= '0;
         low_q      <= '0;
         rx_valid_q <= 1'b0;
         err_ovf_q  <= 1'b0;
         err_to_q   <= 1'b0;
         corr_q     <= '0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         rx_ena_q   <= rx_ena_d;
         to_cnt_q   <= to_cnt_d;
         low_q      <= low_d;
         rx_valid_q <= bus.rx_valid;
         err_ovf_q  <= err_ovf_d;
         err_to_q   <= err_to_d;
         corr_q     <= corr_d;
      end
   end

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  ({dec_nib, low_q}),
      .pop_i   (pop),
      .data_o  (bus.out_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bus.out_valid = ~fifo_empty;
   assign err_overflow  = err_ovf_q;
   assign err_timeout   = err_to_q;
   assign corr_cnt      = corr_q;
   assign busy          = (state_q == WAIT_HI) | (bus.rx_state != RX_IDLE);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a Hamming encoder builds codewords,
// expected bytes go to a scoreboard queue when the high nibble is driven and
// are compared as the consumer pops them.
module tb_uart_rx_ctrl;
   localparam int unsigned Cps   = 4;
   localparam int unsigned To    = 4;
   localparam int unsigned Depth = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       clr_err = 1'b0;
   logic       err_overflow, err_timeout, busy;
   logic [7:0] corr_cnt;

   uart_rx_ctrl_if bus ();

   uart_rx_ctrl #(
      .CLKS_PER_SAMPLE (Cps),
      .TIMEOUT_TICKS   (To),
      .FIFO_DEPTH      (Depth)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .bus          (bus),
      .clr_err      (clr_err),
      .err_overflow (err_overflow),
      .err_timeout  (err_timeout),
      .corr_cnt     (corr_cnt),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] sb_q[$];
   bit         pending = 1'b0;
   logic [3:0] low_nib = '0;
   logic       exp_ovf = 1'b0;
   logic [7:0] exp_corr = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] hamming_enc(input logic [3:0] n);
      logic p1, p2, p4;
      p1 = n[0] ^ n[1] ^ n[3];
      p2 = n[0] ^ n[2] ^ n[3];
      p4 = n[1] ^ n[2] ^ n[3];
      return {n[3], n[2], n[1], p4, n[0], p2, p1};
   endfunction

   // One codeword event; flip<0 means no injected error.
   task automatic send_nib(input logic [3:0] nib, input int flip, input logic ready);
      logic [6:0] cw;
      cw = hamming_enc(nib);
      if (flip >= 0) cw[flip] = ~cw[flip];
      @(posedge clk); #1;
      bus.rx_data   = cw;
      bus.rx_valid  = 1'b1;
      bus.out_ready = ready;
      if (flip >= 0 && exp_corr != 8'hFF) exp_corr = exp_corr + 8'd1;
      if (!pending) begin
         pending = 1'b1;
         low_nib = nib;
      end else begin
         pending = 1'b0;
         if (sb_q.size() >= int'(Depth) && !ready) exp_ovf = 1'b1;
         else sb_q.push_back({nib, low_nib});
      end
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_pair(input logic [3:0] lo, input logic [3:0] hi, input logic ready);
      send_nib(lo, -1, ready);
      send_nib(hi, -1, ready);
   endtask

   task automatic wait_ena(input string tag, input int exp);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.rx_ena && n < 200);
      check_eq(tag, n, exp);
   endtask

   task automatic count_ticks(input int k);
      int n = 0;
      int guard = 0;
      while (n < k && guard < 1000) begin
         @(negedge clk);
         guard++;
         if (bus.rx_ena) n++;
      end
      check_eq("tick_bound", n, k);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, sb_q.size(), 0);
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1;
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err  = 1'b0;
      exp_ovf  = 1'b0;
      exp_corr = '0;
   endtask

   // Consumer-side scoreboard.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) check_eq("sb_underflow", 32'(bus.out_valid), 32'd0);
         else check_eq("out_data", 32'(bus.out_data), 32'(sb_q.pop_front()));
      end
   end

   initial begin
      bus.rx_data   = '0;
      bus.rx_valid  = 1'b0;
      bus.rx_state  = 2'b00;
      bus.out_ready = 1'b0;
      en            = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_rx_ena", 32'(bus.rx_ena), 32'd0);
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
      check_eq("rst_err_ovf", 32'(err_overflow), 32'd0);
      check_eq("rst_err_to", 32'(err_timeout), 32'd0);
      check_eq("rst_corr", 32'(corr_cnt), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      wait_ena("first_ena", Cps);
      wait_ena("ena_period", Cps);

      // Clean pair -> A5, single-cycle valid.
      send_nib(4'h5, -1, 1'b1);
      check_eq("busy_wait_hi", 32'(busy), 32'd1);
      send_nib(4'hA, -1, 1'b1);
      @(negedge clk);
      check_eq("valid_n1", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
      check_eq("valid_n2", 32'(bus.out_valid), 32'd0);
      check_eq("corr_clean", 32'(corr_cnt), 32'(exp_corr));
      check_eq("busy_idle", 32'(busy), 32'd0);

      // Corrected codeword 7'h3D, then clear, then clear racing a correction.
      send_nib(4'h5, 4, 1'b1);
      send_nib(4'hA, -1, 1'b1);
      @(negedge clk);
      check_eq("corr_one", 32'(corr_cnt), 32'(exp_corr));
      pulse_clr();
      check_eq("corr_clr", 32'(corr_cnt), 32'(exp_corr));
      clr_err = 1'b1;
      send_nib(4'h5, 0, 1'b1);
      clr_err = 1'b0;
      check_eq("corr_clr_race", 32'(corr_cnt), 32'(exp_corr));
      send_nib(4'hA, -1, 1'b1);
      wait_drain("drain_corr");
      pulse_clr();

      // Timeout, frozen while a frame is in flight.
      send_nib(4'h5, -1, 1'b1);
      bus.rx_state = 2'b01;
      count_ticks(6);
      check_eq("to_frozen", 32'(err_timeout), 32'd0);
      check_eq("busy_frame", 32'(busy), 32'd1);
      @(posedge clk); #1;
      bus.rx_state = 2'b00;
      count_ticks(To);
      check_eq("to_early", 32'(err_timeout), 32'd0);
      @(negedge clk);
      check_eq("to_set", 32'(err_timeout), 32'd1);
      check_eq("to_busy", 32'(busy), 32'd0);
      pending = 1'b0;
      pulse_clr();
      check_eq("to_clr", 32'(err_timeout), 32'd0);
      send_pair(4'h5, 4'hA, 1'b1);
      wait_drain("drain_to");

      // en dropped in WAIT_HI discards the low nibble silently.
      send_nib(4'h7, -1, 1'b1);
      @(posedge clk); #1;
      en = 1'b0;
      @(posedge clk); #1;
      en = 1'b1;
      pending = 1'b0;
      check_eq("en_busy", 32'(busy), 32'd0);
      check_eq("en_no_to", 32'(err_timeout), 32'd0);
      wait_ena("ena_after_en", Cps);
      send_pair(4'h3, 4'hC, 1'b1);
      wait_drain("drain_en");

      // Overflow: five pairs into a four-entry FIFO.
      for (int i = 0; i < 4; i++) send_pair(4'(i + 1), 4'(8 + i), 1'b0);
      @(negedge clk);
      check_eq("ovf_not_yet", 32'(err_overflow), 32'(exp_ovf));
      check_eq("ovf_held", 32'(bus.out_valid), 32'd1);
      send_pair(4'hF, 4'hE, 1'b0);
      @(negedge clk);
      check_eq("ovf_set", 32'(err_overflow), 32'(exp_ovf));
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      wait_drain("drain_ovf");
      pulse_clr();

      // Full FIFO with a simultaneous pop accepts the new byte.
      for (int i = 0; i < 4; i++) send_pair(4'(i + 4), 4'(15 - i), 1'b0);
      send_nib(4'h1, -1, 1'b0);
      send_nib(4'h2, -1, 1'b1);
      wait_drain("drain_full");
      check_eq("full_no_ovf", 32'(err_overflow), 32'(exp_ovf));

      // Reset while WAIT_HI with two bytes queued.
      send_pair(4'h6, 4'h1, 1'b0);
      send_pair(4'h7, 4'h2, 1'b0);
      send_nib(4'h6, -1, 1'b0);
      check_eq("pre_rst_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      sb_q.delete();
      pending  = 1'b0;
      exp_corr = '0;
      exp_ovf  = 1'b0;
      @(negedge clk);
      check_eq("mrst_valid", 32'(bus.out_valid), 32'd0);
      check_eq("mrst_busy", 32'(busy), 32'd0);
      check_eq("mrst_data", 32'(bus.out_data), 32'd0);
      rst = 1'b0;
      wait_ena("ena_after_rst", Cps);
      send_pair(4'h9, 4'hE, 1'b1);
      wait_drain("drain_rst");

      check_eq("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
